// File: rtl/ads131_pkg.sv
// Shared types and default geometry for the ADS131 frame receiver.
package ads131_pkg;

  localparam int unsigned DEF_WORD_BITS    = 24;
  localparam int unsigned DEF_NUM_CHANNELS = 4;
  localparam int unsigned STATUS_BITS      = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_COMPLETE = 2'd2
  } rx_state_e;

  // Counter width for a counter spanning 0..range-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer bringing one asynchronous bit into the system_clock domain.
module bit_synchronizer (
  input  logic system_clock,
  input  logic reset_n,
  input  logic async_bit,
  output logic sync_bit
);

  logic meta_q;

  // Two-stage capture; both stages clear on reset.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_bit <= 1'b0;
    end else begin
      meta_q   <= async_bit;
      sync_bit <= meta_q;
    end
  end

endmodule

// File: rtl/ads131_frame_receiver.sv
// Receives one ADS131 SPI frame (status word + channel words, CPHA=1, MSB first)
// by oversampling SCLK/MISO/CS on system_clock and publishes complete frames only.
module ads131_frame_receiver
  import ads131_pkg::*;
#(
  parameter int unsigned WORD_BITS    = DEF_WORD_BITS,
  parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS
) (
  input  logic                              system_clock,
  input  logic                              reset_n,
  input  logic                              frame_active,
  input  logic                              spi_sclk,
  input  logic                              spi_miso,
  output logic [STATUS_BITS-1:0]            status_word,
  output logic [NUM_CHANNELS*WORD_BITS-1:0] ch_data,
  output logic                              frame_valid,
  output logic                              frame_error,
  output logic                              busy
);

  localparam int unsigned NUM_WORDS = NUM_CHANNELS + 1;
  localparam int unsigned BIT_W     = cnt_width(WORD_BITS);
  localparam int unsigned WORD_W    = cnt_width(NUM_WORDS);
  localparam int unsigned CH_BITS   = NUM_CHANNELS * WORD_BITS;

  logic sclk_s, miso_s, act_s;
  logic sclk_prev_q, act_prev_q;
  logic [1:0] settle_q;
  logic armed_q;

  rx_state_e state_q, state_d;

  logic [BIT_W-1:0]     bit_cnt_q;
  logic [WORD_W-1:0]    word_cnt_q;
  logic [WORD_BITS-1:0] word_sr_q;
  logic [WORD_BITS-1:0] stage_q [NUM_WORDS];

  logic sclk_fall_c, act_rise_c, sample_c, word_done_c, last_word_c;
  logic start_c, load_c, short_c;
  logic [WORD_BITS-1:0]   word_next_c;
  logic [STATUS_BITS-1:0] status_c;
  logic [CH_BITS-1:0]     ch_next_c;

  bit_synchronizer u_sync_sclk (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .async_bit    (spi_sclk),
    .sync_bit     (sclk_s)
  );

  bit_synchronizer u_sync_miso (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .async_bit    (spi_miso),
    .sync_bit     (miso_s)
  );

  bit_synchronizer u_sync_act (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .async_bit    (frame_active),
    .sync_bit     (act_s)
  );

  // Edge history; CS must be seen low after the synchronizer settles before a
  // frame can start, so a CS still held across reset never opens a frame.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q <= 1'b0;
      act_prev_q  <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      act_prev_q  <= act_s;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd3 && !act_s) armed_q <= 1'b1;
    end
  end

  // A falling edge that coincides with CS release is dropped via the act_s term.
  assign sclk_fall_c = !sclk_s && sclk_prev_q;
  assign act_rise_c  = act_s && !act_prev_q;
  assign sample_c    = sclk_fall_c && act_s && (state_q == ST_SHIFT);
  assign word_done_c = (bit_cnt_q == BIT_W'(WORD_BITS - 1));
  assign last_word_c = (word_cnt_q == WORD_W'(NUM_CHANNELS));
  assign word_next_c = WORD_BITS'({word_sr_q, miso_s});

  // State register.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (act_rise_c && armed_q) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (!act_s)                                      state_d = ST_IDLE;
        else if (sample_c && word_done_c && last_word_c) state_d = ST_COMPLETE;
      end
      ST_COMPLETE: if (!act_s) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    start_c = 1'b0;
    load_c  = 1'b0;
    short_c = 1'b0;
    case (state_q)
      ST_IDLE:  start_c = act_rise_c && armed_q;
      ST_SHIFT: begin
        if (!act_s)                                      short_c = 1'b1;
        else if (sample_c && word_done_c && last_word_c) load_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Bit/word counters, shift register and staging buffer.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      word_sr_q  <= '0;
      for (int i = 0; i < int'(NUM_WORDS); i++) stage_q[i] <= '0;
    end else if (start_c) begin
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else if (sample_c) begin
      word_sr_q <= word_next_c;
      if (word_done_c) begin
        bit_cnt_q           <= '0;
        stage_q[word_cnt_q] <= word_next_c;
        word_cnt_q          <= last_word_c ? '0 : word_cnt_q + WORD_W'(1);
      end else begin
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end
    end
  end

  // Published values: earlier words from staging, the final word straight from the shifter.
  always_comb begin
    status_c  = STATUS_BITS'({stage_q[0], {STATUS_BITS{1'b0}}} >> WORD_BITS);
    ch_next_c = '0;
    for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
      ch_next_c[k*WORD_BITS +: WORD_BITS] =
        (k == int'(NUM_CHANNELS) - 1) ? word_next_c : stage_q[k+1];
    end
  end

  // Registered outputs; data only moves on a complete frame.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      status_word <= '0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (load_c) begin
        status_word <= status_c;
        ch_data     <= ch_next_c;
      end
      frame_valid <= load_c;
      frame_error <= short_c;
      busy        <= (state_d == ST_SHIFT);
    end
  end

endmodule

// File: tb/tb_ads131_frame_receiver.sv
// Randomized bench for ads131_frame_receiver against a frame-level reference model.
module tb_ads131_frame_receiver;

  localparam int WB    = 24;
  localparam int NC    = 4;
  localparam int NBITS = (NC + 1) * WB;

  logic system_clock = 1'b0;
  logic reset_n, frame_active, spi_sclk, spi_miso;
  logic [15:0]      status_word;
  logic [NC*WB-1:0] ch_data;
  logic             frame_valid, frame_error, busy;

  ads131_frame_receiver #(.WORD_BITS(WB), .NUM_CHANNELS(NC)) dut (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .frame_active (frame_active),
    .spi_sclk     (spi_sclk),
    .spi_miso     (spi_miso),
    .status_word  (status_word),
    .ch_data      (ch_data),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 system_clock = ~system_clock;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  // Pulse counters sampled mid-cycle.
  always @(negedge system_clock) begin
    if (frame_valid) vld_cnt++;
    if (frame_error) err_cnt++;
  end

  // Reference state: what the outputs must hold, derived from frames sent.
  logic [15:0]      exp_status;
  logic [NC*WB-1:0] exp_ch;
  logic [15:0]      cur_status;
  logic [WB-1:0]    cur_ch [NC];
  logic             frame_bits [NBITS];

  task automatic check(input string tag, input logic [NC*WB-1:0] got, input logic [NC*WB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  task automatic rand_frame();
    cur_status = 16'($urandom);
    for (int k = 0; k < NC; k++) cur_ch[k] = WB'($urandom);
  endtask

  // Serialize status (padded with a zero byte) then channels, MSB first.
  task automatic build_frame();
    logic [WB-1:0] word;
    for (int i = 0; i < NBITS; i++) begin
      word = (i / WB == 0) ? {cur_status, 8'h00} : cur_ch[i/WB - 1];
      frame_bits[i] = word[WB - 1 - (i % WB)];
    end
  endtask

  // Data changes with SCLK high, ADC samples on the falling edge.
  task automatic send_bits(input int n, input int hp, input int extra);
    for (int i = 0; i < n + extra; i++) begin
      spi_sclk = 1'b1;
      spi_miso = (i < n) ? frame_bits[i] : 1'($urandom);
      wait_cyc(hp);
      spi_sclk = 1'b0;
      wait_cyc(hp);
    end
  endtask

  task automatic run_frame(input string tag, input int nbits, input int hp, input int extra, input int gap);
    frame_active = 1'b1;
    wait_cyc(6);
    check({tag, "_busy"}, NC*WB'(busy), NC*WB'(1));
    send_bits(nbits, hp, extra);
    wait_cyc(4);
    frame_active = 1'b0;
    wait_cyc(gap);
  endtask

  task automatic do_frame(input string tag, input int nbits, input int hp, input int extra);
    int v0 = vld_cnt;
    int e0 = err_cnt;
    build_frame();
    run_frame(tag, nbits, hp, extra, 8);
    if (nbits >= NBITS) begin
      exp_status = cur_status;
      for (int k = 0; k < NC; k++) exp_ch[k*WB +: WB] = cur_ch[k];
      check({tag, "_nvalid"}, NC*WB'(vld_cnt - v0), NC*WB'(1));
      check({tag, "_nerror"}, NC*WB'(err_cnt - e0), NC*WB'(0));
    end else begin
      check({tag, "_nvalid"}, NC*WB'(vld_cnt - v0), NC*WB'(0));
      check({tag, "_nerror"}, NC*WB'(err_cnt - e0), NC*WB'(1));
    end
    check({tag, "_status"}, NC*WB'(status_word), NC*WB'(exp_status));
    check({tag, "_ch"}, ch_data, exp_ch);
  endtask

  initial begin
    int v0, e0, hp, nb;
    reset_n = 1'b0;
    frame_active = 1'b0;
    spi_sclk = 1'b0;
    spi_miso = 1'b0;
    exp_status = '0;
    exp_ch = '0;
    wait_cyc(3);
    check("rst_status", NC*WB'(status_word), '0);
    check("rst_ch", ch_data, '0);
    check("rst_valid", NC*WB'(frame_valid), '0);
    check("rst_error", NC*WB'(frame_error), '0);
    check("rst_busy", NC*WB'(busy), '0);
    reset_n = 1'b1;
    wait_cyc(6);

    // Directed extreme channel values.
    cur_status = 16'h2200;
    cur_ch[0] = 24'h7FFFFF;
    cur_ch[1] = 24'h800000;
    cur_ch[2] = 24'h000001;
    cur_ch[3] = 24'hFFFFFF;
    do_frame("full", NBITS, 4, 0);

    // Short frame keeps previous outputs.
    rand_frame();
    do_frame("short50", 50, 4, 0);

    // Trailing SCLK after a complete frame is ignored.
    rand_frame();
    do_frame("extra8", NBITS, 4, 8);

    // Reset in mid-frame while CS stays asserted.
    rand_frame();
    build_frame();
    v0 = vld_cnt;
    e0 = err_cnt;
    frame_active = 1'b1;
    wait_cyc(6);
    send_bits(60, 4, 0);
    reset_n = 1'b0;
    wait_cyc(3);
    exp_status = '0;
    exp_ch = '0;
    check("midrst_ch", ch_data, exp_ch);
    check("midrst_busy", NC*WB'(busy), '0);
    reset_n = 1'b1;
    wait_cyc(10);
    check("midrst_norestart", NC*WB'(busy), '0);
    frame_active = 1'b0;
    wait_cyc(6);
    check("midrst_nerror", NC*WB'(err_cnt - e0), '0);
    check("midrst_nvalid", NC*WB'(vld_cnt - v0), '0);
    rand_frame();
    cur_ch[0] = 24'h123456;
    do_frame("after_rst", NBITS, 4, 0);

    // Back-to-back frames with a 2-cycle CS gap.
    v0 = vld_cnt;
    rand_frame();
    build_frame();
    run_frame("b2b_a", NBITS, 3, 0, 2);
    rand_frame();
    do_frame("b2b_b", NBITS, 3, 0);
    check("b2b_total_valid", NC*WB'(vld_cnt - v0), NC*WB'(2));

    // Minimum SCLK half-period.
    rand_frame();
    do_frame("hp3", NBITS, 3, 0);

    // Random frames: random rates, some cut short, some with trailing clocks.
    for (int it = 0; it < 8; it++) begin
      rand_frame();
      hp = $urandom_range(3, 6);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NBITS - 1) : NBITS;
      do_frame($sformatf("rnd%0d", it), nb, hp, (nb == NBITS) ? $urandom_range(0, 3) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ads131_frame_receiver.md
ADS131_FRAME_RECEIVER -- requirements
Module: ads131_frame_receiver

Interface
REQ-001 The block SHALL have parameter WORD_BITS, default 24, meaning bits per SPI word.
REQ-002 The block SHALL have parameter NUM_CHANNELS, default 4, meaning data words following the status word.
REQ-003 The block SHALL have port system_clock, input, width 1, the single clock for all logic.
REQ-004 The block SHALL have port reset_n, input, width 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port frame_active, input, width 1, high while CS is asserted for one transaction.
REQ-006 The block SHALL have port spi_sclk, input, width 1, the SPI clock from the SCLK generator, idle low.
REQ-007 The block SHALL have port spi_miso, input, width 1, the ADC data-out line.
REQ-008 The block SHALL have port status_word, output, width 16, the upper 16 bits of frame word 0.
REQ-009 The block SHALL have port ch_data, output, width NUM_CHANNELS*WORD_BITS; channel k occupies bits [k*WORD_BITS +: WORD_BITS], two's complement, unmodified.
REQ-010 The block SHALL have port frame_valid, output, width 1, a one-cycle pulse when status_word and ch_data are updated.
REQ-011 The block SHALL have port frame_error, output, width 1, a one-cycle pulse on a short frame.
REQ-012 The block SHALL have port busy, output, width 1, high in SHIFT state.

Function
REQ-013 spi_sclk, spi_miso and frame_active SHALL each pass through a 2-flop synchronizer; all logic SHALL use the synchronized copies only.
REQ-014 A falling edge SHALL be detected when synchronized sclk is 0 and its previous-cycle value is 1; MISO SHALL be sampled in that same cycle (CPHA=1, MSB first).
REQ-015 States: IDLE, SHIFT, COMPLETE.
- IDLE -> SHIFT on rising edge of synchronized frame_active; bit and word counters cleared.
- SHIFT -> COMPLETE after (NUM_CHANNELS+1)*WORD_BITS sampled bits.
- SHIFT -> IDLE if frame_active falls first.
- COMPLETE -> IDLE when frame_active is low.
REQ-016 In SHIFT each sample SHALL shift into a WORD_BITS shift register; on the WORD_BITS-th bit, the word SHALL go to the staging buffer slot given by the word counter, and the bit counter SHALL wrap to 0.
REQ-017 status_word and ch_data SHALL update only from a complete staging buffer, in the cycle after the final bit is sampled; frame_valid SHALL be high in that same cycle.
REQ-018 Short frame, meaning frame_active falls in SHIFT: frame_error SHALL pulse for one cycle, outputs SHALL hold their previous values, and frame_valid SHALL stay low.
REQ-019 SCLK edges in IDLE or COMPLETE SHALL be ignored, so extra clocks after a full frame do not corrupt outputs.
REQ-020 A falling edge coinciding with frame_active deassertion SHALL be discarded and SHALL be treated as a short frame if in SHIFT.
REQ-021 Counter widths SHALL be $clog2 of their ranges; there SHALL be no overflow at any parameter value >= 1.

Reset
REQ-022 On reset_n low, state SHALL become IDLE, and all synchronizers, counters, the shift register and the staging buffer SHALL clear to 0.
REQ-023 On reset_n low, status_word, ch_data, frame_valid, frame_error and busy SHALL be 0.
REQ-024 Reset during SHIFT SHALL abandon the frame without a frame_error pulse; after release, a new frame SHALL start only on a fresh frame_active rising edge.

Structure
REQ-025 Package ads131_pkg SHALL hold the state enum and default WORD_BITS/NUM_CHANNELS constants.
REQ-026 Sub-module bit_synchronizer, a 2-flop synchronizer with async active-low reset, SHALL be instantiated three times.

Verification
REQ-027 Full frame of 120 bits with status 0x2200 padded with 0x00, channels 0x7FFFFF, 0x800000, 0x000001, 0xFFFFFF -> one frame_valid; status_word=0x2200; ch_data slots match exactly.
REQ-028 frame_active drops after 50 bits -> frame_error pulse; frame_valid=0; outputs keep the prior frame values.
REQ-029 Full frame followed by 8 extra SCLK cycles before CS release -> exactly one frame_valid; data unchanged.
REQ-030 reset_n pulsed low at bit 60, then a full frame with ch0=0x123456 -> no error pulse; a single frame_valid; ch0=0x123456.
REQ-031 Two back-to-back frames, CS high for 2 cycles between them -> two frame_valid pulses; second frame's data present after the second pulse.
REQ-032 SCLK half-period of 3 system_clock cycles (minimum) -> all 120 bits captured correctly.
